// File: rtl/ps_bc_arb.sv
// Bus-connect arbiter: decoded instructions vs. the interrupt context-save engine.
// Drives the registered DRR/DI mux selects and the status-stack push strobe.
module ps_bc_arb #(
  parameter int unsigned NSAVE     = 3,
  parameter logic [31:0] SAVE_LIST = 32'h0063_7B7C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps_inst_req,
  input  logic [1:0] ps_inst_type,
  input  logic [7:0] ps_inst_ureg_add,
  input  logic       ps_save_req,
  output logic [1:0] ps_bc_drr_slct,
  output logic [1:0] ps_bc_di_slct,
  output logic       ps_bc_push,
  output logic       ps_stall,
  output logic       ps_save_done,
  output logic       ps_arb_err
);

  localparam int unsigned SELW  = 2;
  localparam int unsigned ADDRW = 8;
  localparam logic [SELW-1:0] LAST_BEAT = SELW'(NSAVE - 1);

  typedef enum logic [1:0] {IDLE, SAVE, REPLAY} state_t;

  state_t             state_q;
  logic [SELW-1:0]    beat_q;
  logic               pend_vld_q;
  logic [1:0]         pend_type_q;
  logic [ADDRW-1:0]   pend_addr_q;
  logic [SELW-1:0]    drr_q;
  logic [SELW-1:0]    di_q;
  logic               push_q;
  logic               last_q;
  logic               done_q;
  logic               err_q;
  logic [ADDRW-1:0]   save_addr;

  // Map a ureg source address group onto the DRR mux input
  function automatic logic [SELW-1:0] src_decode(input logic [ADDRW-1:0] addr);
    case (addr[7:4])
      4'h0:       src_decode = 2'b10;
      4'h6, 4'h7: src_decode = 2'b01;
      4'h1, 4'h2: src_decode = 2'b00;
      default:    src_decode = 2'b11;
    endcase
  endfunction

  // DRR select for an instruction grant
  function automatic logic [SELW-1:0] inst_drr(input logic [1:0] typ, input logic [ADDRW-1:0] addr);
    case (typ)
      2'b00:   inst_drr = src_decode(addr);
      2'b11:   inst_drr = 2'b01;
      default: inst_drr = 2'b11;
    endcase
  endfunction

  // DI select for an instruction grant
  function automatic logic [SELW-1:0] inst_di(input logic [1:0] typ);
    case (typ)
      2'b00:   inst_di = 2'b01;
      2'b01:   inst_di = 2'b00;
      2'b10:   inst_di = 2'b10;
      default: inst_di = 2'b01;
    endcase
  endfunction

  // Ureg address pushed on the current save beat
  assign save_addr = SAVE_LIST[{beat_q, 3'b000} +: ADDRW];

  // Sequencer stall: bus busy, or a colliding instruction is being parked
  assign ps_stall = (state_q != IDLE) | (ps_save_req & ps_inst_req);

  // Arbitration FSM with registered selects, push, done and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      pend_vld_q  <= 1'b0;
      pend_type_q <= '0;
      pend_addr_q <= '0;
      drr_q       <= 2'b11;
      di_q        <= 2'b11;
      push_q      <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      drr_q  <= 2'b11;
      di_q   <= 2'b11;
      push_q <= 1'b0;
      last_q <= 1'b0;
      done_q <= last_q;
      case (state_q)
        IDLE: begin
          if (ps_save_req) begin
            state_q <= SAVE;
            beat_q  <= '0;
            if (ps_inst_req) begin
              pend_vld_q  <= 1'b1;
              pend_type_q <= ps_inst_type;
              pend_addr_q <= ps_inst_ureg_add;
            end
          end else if (ps_inst_req) begin
            drr_q <= inst_drr(ps_inst_type, ps_inst_ureg_add);
            di_q  <= inst_di(ps_inst_type);
          end
        end
        SAVE: begin
          drr_q  <= src_decode(save_addr);
          di_q   <= 2'b01;
          push_q <= 1'b1;
          if (ps_save_req) err_q <= 1'b1;
          if (ps_inst_req) begin
            if (pend_vld_q) begin
              err_q <= 1'b1;
            end else begin
              pend_vld_q  <= 1'b1;
              pend_type_q <= ps_inst_type;
              pend_addr_q <= ps_inst_ureg_add;
            end
          end
          if (beat_q == LAST_BEAT) begin
            beat_q  <= '0;
            last_q  <= 1'b1;
            state_q <= (pend_vld_q | ps_inst_req) ? REPLAY : IDLE;
          end else begin
            beat_q <= beat_q + 2'd1;
          end
        end
        REPLAY: begin
          drr_q      <= inst_drr(pend_type_q, pend_addr_q);
          di_q       <= inst_di(pend_type_q);
          pend_vld_q <= 1'b0;
          state_q    <= IDLE;
          if (ps_save_req | ps_inst_req) err_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ps_bc_drr_slct = drr_q;
  assign ps_bc_di_slct  = di_q;
  assign ps_bc_push     = push_q;
  assign ps_save_done   = done_q;
  assign ps_arb_err     = err_q;

endmodule

// File: tb/tb_ps_bc_arb.sv
// Scoreboard bench for ps_bc_arb: each driven cycle queues the registered
// outputs expected after the next edge; they are popped and compared there.
module tb_ps_bc_arb;

  logic       clk;
  logic       rst;
  logic       ps_inst_req;
  logic [1:0] ps_inst_type;
  logic [7:0] ps_inst_ureg_add;
  logic       ps_save_req;
  logic [1:0] ps_bc_drr_slct;
  logic [1:0] ps_bc_di_slct;
  logic       ps_bc_push;
  logic       ps_stall;
  logic       ps_save_done;
  logic       ps_arb_err;

  typedef struct packed {
    logic [1:0] drr;
    logic [1:0] di;
    logic       push;
    logic       done;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass;
  int   n_total;

  ps_bc_arb dut (
    .clk              (clk),
    .rst              (rst),
    .ps_inst_req      (ps_inst_req),
    .ps_inst_type     (ps_inst_type),
    .ps_inst_ureg_add (ps_inst_ureg_add),
    .ps_save_req      (ps_save_req),
    .ps_bc_drr_slct   (ps_bc_drr_slct),
    .ps_bc_di_slct    (ps_bc_di_slct),
    .ps_bc_push       (ps_bc_push),
    .ps_stall         (ps_stall),
    .ps_save_done     (ps_save_done),
    .ps_arb_err       (ps_arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Drive one cycle, check combinational stall, queue and then compare the
  // registered outputs expected after the following clock edge
  task automatic cyc(input string tag, input logic r, input logic sv, input logic iq,
                     input logic [1:0] ty, input logic [7:0] ad, input logic es,
                     input logic [1:0] edrr, input logic [1:0] edi,
                     input logic epu, input logic edn, input logic eer);
    exp_t e;
    exp_t o;
    @(negedge clk);
    rst              = r;
    ps_save_req      = sv;
    ps_inst_req      = iq;
    ps_inst_type     = ty;
    ps_inst_ureg_add = ad;
    #1;
    check({tag, ".stall"}, 32'(ps_stall), 32'(es));
    e.drr = edrr; e.di = edi; e.push = epu; e.done = edn; e.err = eer;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      o = exp_q.pop_front();
      check({tag, ".drr"},  32'(ps_bc_drr_slct), 32'(o.drr));
      check({tag, ".di"},   32'(ps_bc_di_slct),  32'(o.di));
      check({tag, ".push"}, 32'(ps_bc_push),     32'(o.push));
      check({tag, ".done"}, 32'(ps_save_done),   32'(o.done));
      check({tag, ".err"},  32'(ps_arb_err),     32'(o.err));
    end
  endtask

  // Hard stop if the run ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_pass           = 0;
    n_total          = 0;
    rst              = 1'b1;
    ps_inst_req      = 1'b0;
    ps_inst_type     = 2'b00;
    ps_inst_ureg_add = 8'h00;
    ps_save_req      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.drr",  32'(ps_bc_drr_slct), 32'd3);
    check("rst.di",   32'(ps_bc_di_slct),  32'd3);
    check("rst.push", 32'(ps_bc_push),     32'd0);
    check("rst.done", 32'(ps_save_done),   32'd0);
    check("rst.err",  32'(ps_arb_err),     32'd0);

    // Single type-00 transfer from ureg 0x05
    cyc("i00",  0, 0, 1, 2'b00, 8'h05, 0, 2'b10, 2'b01, 0, 0, 0);
    cyc("idl0", 0, 0, 0, 2'b00, 8'h00, 0, 2'b11, 2'b11, 0, 0, 0);

    // Back-to-back types 01, 10, 11
    cyc("i01",  0, 0, 1, 2'b01, 8'h63, 0, 2'b11, 2'b00, 0, 0, 0);
    cyc("i10",  0, 0, 1, 2'b10, 8'h63, 0, 2'b11, 2'b10, 0, 0, 0);
    cyc("i11",  0, 0, 1, 2'b11, 8'h63, 0, 2'b01, 2'b01, 0, 0, 0);
    cyc("idl1", 0, 0, 0, 2'b00, 8'h00, 0, 2'b11, 2'b11, 0, 0, 0);

    // Plain context save: beats 7C, 7B, 63 then done
    cyc("sv.req", 0, 1, 0, 2'b00, 8'h00, 0, 2'b11, 2'b11, 0, 0, 0);
    cyc("sv.b0",  0, 0, 0, 2'b00, 8'h00, 1, 2'b01, 2'b01, 1, 0, 0);
    cyc("sv.b1",  0, 0, 0, 2'b00, 8'h00, 1, 2'b01, 2'b01, 1, 0, 0);
    cyc("sv.b2",  0, 0, 0, 2'b00, 8'h00, 1, 2'b01, 2'b01, 1, 0, 0);
    cyc("sv.dn",  0, 0, 0, 2'b00, 8'h00, 0, 2'b11, 2'b11, 0, 1, 0);
    cyc("sv.end", 0, 0, 0, 2'b00, 8'h00, 0, 2'b11, 2'b11, 0, 0, 0);

    // Save and instruction collide: instruction parked, replayed afterwards
    cyc("col.req", 0, 1, 1, 2'b00, 8'h14, 1, 2'b11, 2'b11, 0, 0, 0);
    cyc("col.b0",  0, 0, 0, 2'b00, 8'h00, 1, 2'b01, 2'b01, 1, 0, 0);
    cyc("col.b1",  0, 0, 0, 2'b00, 8'h00, 1, 2'b01, 2'b01, 1, 0, 0);
    cyc("col.b2",  0, 0, 0, 2'b00, 8'h00, 1, 2'b01, 2'b01, 1, 0, 0);
    cyc("col.rp",  0, 0, 0, 2'b00, 8'h00, 1, 2'b00, 2'b01, 0, 1, 0);
    cyc("col.end", 0, 0, 0, 2'b00, 8'h00, 0, 2'b11, 2'b11, 0, 0, 0);

    // Two instructions during save: first replayed, second dropped with error
    cyc("ovf.req", 0, 1, 0, 2'b00, 8'h00, 0, 2'b11, 2'b11, 0, 0, 0);
    cyc("ovf.b0",  0, 0, 1, 2'b01, 8'h00, 1, 2'b01, 2'b01, 1, 0, 0);
    cyc("ovf.b1",  0, 0, 1, 2'b10, 8'h00, 1, 2'b01, 2'b01, 1, 0, 1);
    cyc("ovf.b2",  0, 0, 0, 2'b00, 8'h00, 1, 2'b01, 2'b01, 1, 0, 1);
    cyc("ovf.rp",  0, 0, 0, 2'b00, 8'h00, 1, 2'b11, 2'b00, 0, 1, 1);
    cyc("ovf.e0",  0, 0, 0, 2'b00, 8'h00, 0, 2'b11, 2'b11, 0, 0, 1);
    cyc("ovf.e1",  0, 0, 1, 2'b01, 8'h20, 0, 2'b11, 2'b00, 0, 0, 1);

    // Reset in the middle of a save: no done, error cleared, normal grant after
    cyc("ab.req", 0, 1, 0, 2'b00, 8'h00, 0, 2'b11, 2'b11, 0, 0, 1);
    cyc("ab.b0",  0, 0, 0, 2'b00, 8'h00, 1, 2'b01, 2'b01, 1, 0, 1);
    cyc("ab.rst", 1, 0, 0, 2'b00, 8'h00, 1, 2'b11, 2'b11, 0, 0, 0);
    cyc("ab.idl", 0, 0, 0, 2'b00, 8'h00, 0, 2'b11, 2'b11, 0, 0, 0);
    cyc("ab.i11", 0, 0, 1, 2'b11, 8'h00, 0, 2'b01, 2'b01, 0, 0, 0);
    cyc("ab.i00", 0, 0, 1, 2'b00, 8'hA0, 0, 2'b11, 2'b01, 0, 0, 0);
    cyc("ab.end", 0, 0, 0, 2'b00, 8'h00, 0, 2'b11, 2'b11, 0, 0, 0);

    check("queue.empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
